// File: rtl/hp_pkg.sv
// Shared types and default constants for the soul HP / damage controller.
// The defaults match the battle screen tuning; the top re-exposes them as parameters.
package hp_pkg;

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } hp_state_e;

    localparam int DEF_MAX_HP        = 20;
    localparam int DEF_HP_W          = 7;
    localparam int DEF_DAMAGE        = 3;
    localparam int DEF_HEAL          = 5;
    localparam int DEF_MIN_OVERLAP   = 4;
    localparam int DEF_INVULN_FRAMES = 30;
    localparam int DEF_FLASH_PERIOD  = 4;

    localparam int OVL_W = 10;
    localparam logic [OVL_W-1:0] OVL_MAX = '1;

    localparam int FRAME_CNT_W = 8;

    function automatic logic [OVL_W-1:0] ovl_sat_inc(input logic [OVL_W-1:0] cnt,
                                                      input logic inc);
        if (inc && (cnt != OVL_MAX)) begin
            return cnt + 1'b1;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/hp_damage_ctrl_frame_hit_accum.sv
// Per-frame overlap accumulator: counts collision pixels and flags a hit on frame_end.
// The pixel on the frame_end cycle still belongs to the ending frame.
module frame_hit_accum
    import hp_pkg::*;
#(
    parameter int MIN_OVERLAP = DEF_MIN_OVERLAP
) (
    input  logic Pclk,
    input  logic rst_n,
    input  logic isCollision,
    input  logic frame_end,
    input  logic restart,
    output logic frame_hit
);

    localparam logic [OVL_W-1:0] MIN_OVL = OVL_W'(MIN_OVERLAP);

    logic [OVL_W-1:0] ovl_cnt;
    logic [OVL_W-1:0] ovl_inc;

    assign ovl_inc = ovl_sat_inc(ovl_cnt, isCollision);

    // Resolved on the frame_end cycle itself from the registered count, so the
    // controller's registers capture the decision on that same edge.
    assign frame_hit = frame_end && (ovl_inc >= MIN_OVL);

    always_ff @(posedge Pclk or negedge rst_n) begin
        if (!rst_n) begin
            ovl_cnt <= '0;
        end else if (restart || frame_end) begin
            ovl_cnt <= '0;
        end else begin
            ovl_cnt <= ovl_inc;
        end
    end

endmodule

// File: rtl/hp_damage_ctrl.sv
// Soul HP controller: frame-based hit detection, saturating damage/heal,
// invulnerability frames with blink, and game-over.
//
// state  | meaning
// -------+--------------------------------------------------------------
// ALIVE  | vulnerable; a hit frame applies damage
// INVULN | post-hit grace; hits ignored, blink runs, counts down frames
// DEAD   | hp = 0, game_over high; only restart or reset leaves
module hp_damage_ctrl
    import hp_pkg::*;
#(
    parameter int MAX_HP        = DEF_MAX_HP,
    parameter int HP_W          = DEF_HP_W,
    parameter int DAMAGE        = DEF_DAMAGE,
    parameter int HEAL          = DEF_HEAL,
    parameter int MIN_OVERLAP   = DEF_MIN_OVERLAP,
    parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
    parameter int FLASH_PERIOD  = DEF_FLASH_PERIOD
) (
    input  logic            Pclk,
    input  logic            rst_n,
    input  logic            isCollision,
    input  logic            frame_end,
    input  logic            heal,
    input  logic            restart,
    output logic [HP_W-1:0] hp,
    output logic            hit_pulse,
    output logic            invuln,
    output logic            flash,
    output logic            game_over
);

    localparam logic [HP_W-1:0]        MAX_HP_V   = HP_W'(MAX_HP);
    localparam logic [HP_W:0]          MAX_U      = (HP_W+1)'(MAX_HP);
    localparam logic [HP_W:0]          HEAL_U     = (HP_W+1)'(HEAL);
    localparam logic signed [HP_W+1:0] MAX_S      = (HP_W+2)'(MAX_HP);
    localparam logic signed [HP_W+1:0] DMG_S      = (HP_W+2)'(DAMAGE);
    localparam logic signed [HP_W+1:0] HEAL_S     = (HP_W+2)'(HEAL);
    localparam logic [FRAME_CNT_W-1:0] INV_INIT   = FRAME_CNT_W'(INVULN_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] FLASH_LAST = FRAME_CNT_W'(FLASH_PERIOD - 1);

    hp_state_e              state_q, state_d;
    logic [HP_W-1:0]        hp_q, hp_d;
    logic [FRAME_CNT_W-1:0] invuln_cnt_q, invuln_cnt_d;
    logic [FRAME_CNT_W-1:0] flash_cnt_q, flash_cnt_d;
    logic                   flash_q, flash_d;
    logic                   hit_q, hit_d;
    logic                   invuln_q, game_over_q;

    logic                   frame_hit;
    logic [HP_W:0]          heal_sum;
    logic [HP_W-1:0]        heal_hp;
    logic signed [HP_W+1:0] dmg_sum;
    logic [HP_W-1:0]        dmg_hp;

    frame_hit_accum #(
        .MIN_OVERLAP(MIN_OVERLAP)
    ) u_accum (
        .Pclk       (Pclk),
        .rst_n      (rst_n),
        .isCollision(isCollision),
        .frame_end  (frame_end),
        .restart    (restart),
        .frame_hit  (frame_hit)
    );

    assign heal_sum = {1'b0, hp_q} + HEAL_U;
    assign heal_hp  = (heal_sum > MAX_U) ? MAX_HP_V : heal_sum[HP_W-1:0];

    // Damage with an optional same-cycle heal, clamped to 0..MAX_HP.
    always_comb begin
        dmg_sum = $signed({2'b00, hp_q}) - DMG_S;
        if (heal) begin
            dmg_sum = dmg_sum + HEAL_S;
        end
        if (dmg_sum[HP_W+1]) begin
            dmg_hp = '0;
        end else if (dmg_sum > MAX_S) begin
            dmg_hp = MAX_HP_V;
        end else begin
            dmg_hp = dmg_sum[HP_W-1:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        hp_d         = hp_q;
        invuln_cnt_d = invuln_cnt_q;
        flash_cnt_d  = flash_cnt_q;
        flash_d      = flash_q;
        hit_d        = 1'b0;

        if (restart) begin
            state_d      = ALIVE;
            hp_d         = MAX_HP_V;
            invuln_cnt_d = '0;
            flash_cnt_d  = '0;
            flash_d      = 1'b0;
        end else begin
            case (state_q)
                ALIVE: begin
                    if (frame_hit) begin
                        hit_d = 1'b1;
                        hp_d  = dmg_hp;
                        if (dmg_hp == '0) begin
                            state_d = DEAD;
                        end else begin
                            state_d      = INVULN;
                            invuln_cnt_d = INV_INIT;
                            flash_cnt_d  = '0;
                            flash_d      = 1'b0;
                        end
                    end else if (heal) begin
                        hp_d = heal_hp;
                    end
                end

                INVULN: begin
                    if (heal) begin
                        hp_d = heal_hp;
                    end
                    if (frame_end) begin
                        if (invuln_cnt_q <= FRAME_CNT_W'(1)) begin
                            state_d      = ALIVE;
                            invuln_cnt_d = '0;
                            flash_cnt_d  = '0;
                            flash_d      = 1'b0;
                        end else begin
                            invuln_cnt_d = invuln_cnt_q - 1'b1;
                            if (flash_cnt_q >= FLASH_LAST) begin
                                flash_cnt_d = '0;
                                flash_d     = ~flash_q;
                            end else begin
                                flash_cnt_d = flash_cnt_q + 1'b1;
                            end
                        end
                    end
                end

                DEAD: begin
                    hp_d    = '0;
                    flash_d = 1'b0;
                end

                default: begin
                    state_d = ALIVE;
                end
            endcase
        end
    end

    always_ff @(posedge Pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ALIVE;
            hp_q         <= MAX_HP_V;
            invuln_cnt_q <= '0;
            flash_cnt_q  <= '0;
            flash_q      <= 1'b0;
            hit_q        <= 1'b0;
            invuln_q     <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hp_q         <= hp_d;
            invuln_cnt_q <= invuln_cnt_d;
            flash_cnt_q  <= flash_cnt_d;
            flash_q      <= flash_d;
            hit_q        <= hit_d;
            invuln_q     <= (state_d == INVULN);
            game_over_q  <= (state_d == DEAD);
        end
    end

    assign hp        = hp_q;
    assign hit_pulse = hit_q;
    assign invuln    = invuln_q;
    assign flash     = flash_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_hp_damage_ctrl.sv
// Scoreboard bench for hp_damage_ctrl: stimulus queues expectations, a negedge
// monitor pops and compares them against the DUT.
module tb_hp_damage_ctrl;

    logic       Pclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       isCollision = 1'b0;
    logic       frame_end = 1'b0;
    logic       heal = 1'b0;
    logic       restart = 1'b0;
    logic [6:0] hp;
    logic       hit_pulse, invuln, flash, game_over;

    hp_damage_ctrl dut (
        .Pclk       (Pclk),
        .rst_n      (rst_n),
        .isCollision(isCollision),
        .frame_end  (frame_end),
        .heal       (heal),
        .restart    (restart),
        .hp         (hp),
        .hit_pulse  (hit_pulse),
        .invuln     (invuln),
        .flash      (flash),
        .game_over  (game_over)
    );

    always #20 Pclk = ~Pclk;

    int cyc = 0;
    always @(posedge Pclk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int hp;
        int inv;
        int fl;
        int go;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    hit_q[$];
    int    cnt_cyc_q[$];
    int    cnt_val_q[$];
    string cnt_name_q[$];

    int tests = 0;
    int fails = 0;

    task automatic chk(string nm, int act, int expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Monitor
    always @(negedge Pclk) begin
        if (hit_q.size() > 0 && hit_q[0] == cyc) begin
            chk("hit_pulse", int'(hit_pulse), 1);
            void'(hit_q.pop_front());
        end else if (hit_pulse !== 1'b0) begin
            chk("hit_pulse_spurious", int'(hit_pulse), 0);
        end
        while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk({nm, ".hp"},        int'(hp),        e.hp);
            chk({nm, ".invuln"},    int'(invuln),    e.inv);
            chk({nm, ".flash"},     int'(flash),     e.fl);
            chk({nm, ".game_over"}, int'(game_over), e.go);
        end
        while (cnt_cyc_q.size() > 0 && cnt_cyc_q[0] == cyc) begin
            int    v;
            string nm;
            void'(cnt_cyc_q.pop_front());
            v  = cnt_val_q.pop_front();
            nm = cnt_name_q.pop_front();
            chk(nm, int'(dut.u_accum.ovl_cnt), v);
        end
    end

    task automatic expect_state(string nm, int e_hp, int e_inv, int e_fl, int e_go);
        exp_t e;
        e.cyc = cyc; e.hp = e_hp; e.inv = e_inv; e.fl = e_fl; e.go = e_go;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic expect_cnt(string nm, int v);
        cnt_cyc_q.push_back(cyc);
        cnt_val_q.push_back(v);
        cnt_name_q.push_back(nm);
    endtask

    task automatic step(bit col, bit fe, bit hl, bit rs);
        isCollision = col; frame_end = fe; heal = hl; restart = rs;
        @(posedge Pclk); #1;
        isCollision = 0; frame_end = 0; heal = 0; restart = 0;
    endtask

    task automatic frame(int pix, bit col_fe, bit hl, bit exp_hit);
        for (int i = 0; i < pix; i++) step(1, 0, 0, 0);
        if (exp_hit) hit_q.push_back(cyc + 1);
        step(col_fe, 1, hl, 0);
    endtask

    task automatic hit();
        frame(3, 1, 0, 1);
    endtask

    task automatic expire();
        for (int i = 0; i < 30; i++) frame(0, 0, 0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        #50 rst_n = 1'b1;
        @(posedge Pclk); #1;
        expect_state("reset", 20, 0, 0, 0);
        expect_cnt("reset_cnt", 0);

        frame(3, 0, 0, 0);
        expect_state("below_min", 20, 0, 0, 0);
        hit();
        expect_state("min_overlap_hit", 17, 1, 0, 0);

        for (int k = 1; k <= 30; k++) begin
            repeat (50) step(1, 0, 0, 0);
            expect_state($sformatf("invuln_f%0d", k), 17, 1, (((k - 1) / 4) % 2), 0);
            frame(50, 1, 0, 0);
        end
        expect_state("invuln_expired", 17, 0, 0, 0);

        repeat (5) step(1, 0, 0, 0);
        step(1, 1, 0, 1);
        expect_state("restart_beats_hit", 20, 0, 0, 0);
        expect_cnt("restart_clears_cnt", 0);

        repeat (2000) step(1, 0, 0, 0);
        expect_cnt("cnt_saturated", 1023);
        hit_q.push_back(cyc + 1);
        step(1, 1, 0, 0);
        expect_state("saturated_single_hit", 17, 1, 0, 0);
        expect_cnt("cnt_cleared", 0);

        step(0, 0, 1, 0);
        expect_state("heal_clamped", 20, 1, 0, 0);
        expire();
        expect_state("alive_at_20", 20, 0, 0, 0);
        hit(); expire();
        hit();
        step(0, 0, 1, 0);
        expect_state("heal_unclamped", 19, 1, 0, 0);
        expire();
        hit(); expire();
        hit(); expire();
        hit(); expire();
        expect_state("hp_10", 10, 0, 0, 0);
        frame(3, 1, 1, 1);
        expect_state("heal_with_hit", 12, 1, 0, 0);
        step(0, 0, 1, 0);
        expect_state("heal_in_invuln", 17, 1, 0, 0);
        expire();
        repeat (5) begin
            hit(); expire();
        end
        expect_state("hp_2", 2, 0, 0, 0);
        hit();
        expect_state("dead", 0, 0, 0, 1);
        step(0, 0, 1, 0);
        expect_state("dead_heal", 0, 0, 0, 1);
        frame(3, 1, 0, 0);
        expect_state("dead_hit", 0, 0, 0, 1);
        step(0, 0, 0, 1);
        expect_state("restart_from_dead", 20, 0, 0, 0);

        hit();
        repeat (4) frame(0, 0, 0, 0);
        expect_state("flash_on", 17, 1, 1, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        expect_state("async_reset", 20, 0, 0, 0);
        expect_cnt("async_reset_cnt", 0);
        @(negedge Pclk);
        #5 rst_n = 1'b1;
        @(posedge Pclk); #1;
        expect_state("after_reset", 20, 0, 0, 0);

        repeat (3) step(0, 0, 0, 0);
        chk("exp_queue_drained", exp_q.size(), 0);
        chk("hit_queue_drained", hit_q.size(), 0);
        chk("cnt_queue_drained", cnt_cyc_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
